// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM state
// encoding and default handler vector placement.
package intr_pkg;

    // Register offsets, decoded from dataadr[3:2]
    localparam logic [1:0] STATUS = 2'd0;
    localparam logic [1:0] MASK   = 2'd1;
    localparam logic [1:0] EOI    = 2'd2;
    localparam logic [1:0] INFO   = 2'd3;

    // Default handler vector layout
    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0180;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } state_e;

endpackage

// File: rtl/intr_ctrl_if.sv
// Memory-mapped bus seen by the interrupt controller.
//   sel        : address-decoder select
//   we         : write enable (write happens when sel & we)
//   addr       : register offset
//   write_data : write data
//   data_out   : combinational read data, 0 when sel is low
interface intr_ctrl_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] write_data;
    logic [31:0] data_out;

    modport master (
        output sel,
        output we,
        output addr,
        output write_data,
        input  data_out
    );

    modport slave (
        input  sel,
        input  we,
        input  addr,
        input  write_data,
        output data_out
    );
endinterface

// File: rtl/prio_enc.sv
// Fixed-priority encoder, lowest set index wins.
//   req   : request vector
//   valid : any request set
//   id    : index of the lowest set request (0 when none)
module prio_enc #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [2:0]   id
);

    always_comb begin
        valid = 1'b0;
        id    = 3'd0;
        // Scan downward so the lowest set index is the last one written
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = 3'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches rising edges of peripheral done lines as pending
// bits, applies a software mask, and raises a single request to the core for the
// lowest-numbered enabled pending source.
//   clk, reset : processor clock, synchronous active-high reset
//   bus        : register interface (STATUS, MASK, EOI, INFO)
//   src_done   : peripheral done levels
//   irq        : registered interrupt request
//   irq_ack    : one-cycle acknowledge from the core
//   irq_vec    : handler address for the current source
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int unsigned NSRC       = 2,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    intr_ctrl_if.slave      bus,
    input  logic [NSRC-1:0] src_done,
    output logic            irq,
    input  logic            irq_ack,
    output logic [31:0]     irq_vec
);

    state_e          state_q, state_d;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [2:0]      cur_id_q, cur_id_d;

    logic            wr;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] cur_oh;
    logic [NSRC-1:0] enabled;
    logic            enc_valid;
    logic [2:0]      enc_id;
    logic            cur_pending;
    logic            cur_masked_in;
    logic            in_service;
    logic            eoi_wr;

    assign wr      = bus.sel && bus.we;
    assign eoi_wr  = wr && (bus.addr == EOI);
    assign rise    = src_done & ~src_q;
    assign enabled = pending_q & mask_q;

    prio_enc #(
        .N (NSRC)
    ) u_prio_enc (
        .req   (enabled),
        .valid (enc_valid),
        .id    (enc_id)
    );

    // One-hot of the latched source, used for the acknowledge clear and for
    // watching whether the request has been withdrawn while in REQ.
    always_comb begin
        cur_oh = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            cur_oh[i] = (cur_id_q == 3'(i));
        end
    end

    assign cur_pending   = |(pending_q & cur_oh);
    assign cur_masked_in = |(mask_q & cur_oh);

    // Pending: a new rise wins over a same-cycle W1C or acknowledge clear
    always_comb begin
        clr = '0;
        if (wr && (bus.addr == STATUS)) begin
            clr = clr | bus.write_data[NSRC-1:0];
        end
        if ((state_q == StReq) && irq_ack) begin
            clr = clr | cur_oh;
        end
        pending_d = rise | (pending_q & ~clr);
    end

    always_comb begin
        mask_d = mask_q;
        if (wr && (bus.addr == MASK)) begin
            mask_d = bus.write_data[NSRC-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        unique case (state_q)
            StIdle: begin
                if (enc_valid) begin
                    state_d  = StReq;
                    cur_id_d = enc_id;
                end
            end
            StReq: begin
                if (irq_ack) begin
                    state_d = StService;
                end else if (!cur_pending || !cur_masked_in) begin
                    // Request withdrawn by software before the core took it
                    state_d = StIdle;
                end
            end
            StService: begin
                if (eoi_wr) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // src_q tracks src_done even during reset so a level held through reset
    // is not seen as a rising edge afterwards.
    always_ff @(posedge clk) begin
        src_q <= src_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pending_q <= '0;
            mask_q    <= '0;
            cur_id_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            cur_id_q  <= cur_id_d;
        end
    end

    assign irq        = (state_q == StReq);
    assign in_service = (state_q == StService);
    assign irq_vec    = VEC_BASE + (32'(cur_id_q) * VEC_STRIDE);

    always_comb begin
        bus.data_out = 32'd0;
        if (bus.sel) begin
            case (bus.addr)
                STATUS:  bus.data_out = 32'(pending_q);
                MASK:    bus.data_out = 32'(mask_q);
                EOI:     bus.data_out = 32'd0;
                INFO:    bus.data_out = {in_service, 28'd0, cur_id_q};
                default: bus.data_out = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: register-access table plus hand-written
// interrupt sequences, with expectations queued and consumed on observation.
module tb_intr_ctrl;
    import intr_pkg::*;

    logic       clk;
    logic       reset;
    logic [1:0] src_done;
    logic       irq;
    logic       irq_ack;
    logic [31:0] irq_vec;

    intr_ctrl_if bus ();

    intr_ctrl #(
        .NSRC       (2),
        .VEC_BASE   (32'h0000_0180),
        .VEC_STRIDE (32'h0000_0010)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .src_done (src_done),
        .irq      (irq),
        .irq_ack  (irq_ack),
        .irq_vec  (irq_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string nm, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.val  = v;
        sbq.push_back(e);
    endtask

    task automatic observe(input logic [31:0] act);
        exp_t e;
        n_tests++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %h, required an expectation", act);
        end else begin
            e = sbq.pop_front();
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h, required %h", e.name, act, e.val);
            end
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.sel        = 1'b1;
        bus.we         = 1'b1;
        bus.addr       = a;
        bus.write_data = d;
        tick();
        bus.sel        = 1'b0;
        bus.we         = 1'b0;
        bus.write_data = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.sel  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = a;
        #1;
        d = bus.data_out;
        bus.sel = 1'b0;
    endtask

    task automatic chk_reg(input string nm, input logic [1:0] a, input logic [31:0] v);
        logic [31:0] d;
        expect_v(nm, v);
        rd(a, d);
        observe(d);
    endtask

    task automatic chk_irq(input string nm, input logic v);
        expect_v(nm, {31'd0, v});
        observe({31'd0, irq});
    endtask

    task automatic chk_vec(input string nm, input logic [31:0] v);
        expect_v(nm, v);
        observe(irq_vec);
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        src_done       = 2'b00;
        irq_ack        = 1'b0;
        bus.sel        = 1'b0;
        bus.we         = 1'b0;
        bus.addr       = 2'd0;
        bus.write_data = 32'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk_irq("rst_irq", 1'b0);
        chk_vec("rst_vec", 32'h0000_0180);
        chk_reg("rst_status", STATUS, 32'd0);
        chk_reg("rst_mask", MASK, 32'd0);
        chk_reg("rst_info", INFO, 32'd0);

        // Register access table (FSM idle, nothing pending)
        vecs[0] = '{waddr: MASK,   wdata: 32'h0000_0003, raddr: MASK,   exp: 32'h0000_0003};
        vecs[1] = '{waddr: MASK,   wdata: 32'hFFFF_FFFE, raddr: MASK,   exp: 32'h0000_0002};
        vecs[2] = '{waddr: INFO,   wdata: 32'hFFFF_FFFF, raddr: INFO,   exp: 32'h0000_0000};
        vecs[3] = '{waddr: EOI,    wdata: 32'h0000_0001, raddr: EOI,    exp: 32'h0000_0000};
        vecs[4] = '{waddr: STATUS, wdata: 32'h0000_0003, raddr: STATUS, exp: 32'h0000_0000};
        vecs[5] = '{waddr: MASK,   wdata: 32'h0000_0003, raddr: MASK,   exp: 32'h0000_0003};
        for (int i = 0; i < 6; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata);
            chk_reg($sformatf("table_%0d", i), vecs[i].raddr, vecs[i].exp);
        end
        chk_irq("table_irq", 1'b0);

        // Read data is zero when not selected
        bus.sel  = 1'b0;
        bus.addr = MASK;
        #1;
        expect_v("unsel_read", 32'd0);
        observe(bus.data_out);

        // Single pulse on source 0
        src_done = 2'b01;
        tick();
        src_done = 2'b00;
        chk_reg("p0_status", STATUS, 32'h1);
        chk_irq("p0_irq_lat", 1'b0);
        tick();
        chk_irq("p0_irq", 1'b1);
        chk_vec("p0_vec", 32'h0000_0180);
        chk_reg("p0_info", INFO, 32'h0000_0000);
        ack();
        chk_irq("p0_ack_irq", 1'b0);
        chk_reg("p0_ack_info", INFO, 32'h8000_0000);
        chk_reg("p0_ack_status", STATUS, 32'h0);
        wr(EOI, 32'd0);
        tick();
        chk_irq("p0_eoi_irq", 1'b0);

        // Both sources rise together
        src_done = 2'b11;
        tick();
        src_done = 2'b00;
        tick();
        chk_irq("both_irq", 1'b1);
        chk_vec("both_vec0", 32'h0000_0180);
        ack();
        chk_reg("both_status", STATUS, 32'h2);
        chk_reg("both_info", INFO, 32'h8000_0000);
        chk_irq("both_svc_irq", 1'b0);
        wr(EOI, 32'd0);
        tick();
        chk_irq("both_reassert", 1'b1);
        chk_vec("both_vec1", 32'h0000_0190);
        ack();
        wr(EOI, 32'd0);
        tick();
        chk_irq("both_done", 1'b0);

        // Masked source becomes visible when unmasked
        wr(MASK, 32'h1);
        src_done = 2'b10;
        tick();
        src_done = 2'b00;
        tick();
        tick();
        chk_reg("mask_status", STATUS, 32'h2);
        chk_irq("mask_irq_off", 1'b0);
        wr(MASK, 32'h3);
        tick();
        chk_irq("unmask_irq", 1'b1);
        chk_vec("unmask_vec", 32'h0000_0190);

        // W1C withdraws the request while in REQ
        wr(STATUS, 32'h2);
        chk_irq("w1c_irq_still", 1'b1);
        tick();
        chk_irq("w1c_irq_drop", 1'b0);
        chk_vec("w1c_vec_held", 32'h0000_0190);
        chk_reg("w1c_status", STATUS, 32'h0);

        // Rise beats a same-cycle W1C
        src_done = 2'b10;
        wr(STATUS, 32'h2);
        src_done = 2'b00;
        chk_reg("rise_vs_w1c", STATUS, 32'h2);
        tick();
        chk_irq("rise_vs_w1c_irq", 1'b1);
        ack();
        wr(EOI, 32'd0);
        tick();

        // Level held high produces a single pending set
        src_done = 2'b01;
        tick();
        tick();
        chk_irq("hold_irq", 1'b1);
        ack();
        repeat (18) tick();
        chk_reg("hold_status", STATUS, 32'h0);
        chk_reg("hold_info", INFO, 32'h8000_0000);
        wr(EOI, 32'd0);
        tick();
        chk_irq("hold_idle", 1'b0);

        // Acknowledge while idle is ignored
        ack();
        chk_reg("ack_idle_info", INFO, 32'h0);
        chk_irq("ack_idle_irq", 1'b0);
        src_done = 2'b00;
        tick();

        // EOI while in REQ is ignored
        src_done = 2'b01;
        tick();
        src_done = 2'b00;
        tick();
        wr(EOI, 32'd0);
        chk_irq("eoi_req_irq", 1'b1);
        chk_reg("eoi_req_info", INFO, 32'h0);
        ack();
        wr(EOI, 32'd0);
        tick();

        // Reset during SERVICE with source 1 pending again
        src_done = 2'b10;
        tick();
        src_done = 2'b00;
        tick();
        ack();
        src_done = 2'b10;
        tick();
        chk_reg("pre_rst_status", STATUS, 32'h2);
        chk_reg("pre_rst_info", INFO, 32'h8000_0001);
        chk_vec("pre_rst_vec", 32'h0000_0190);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_irq("mid_rst_irq", 1'b0);
        chk_reg("mid_rst_status", STATUS, 32'h0);
        chk_reg("mid_rst_mask", MASK, 32'h0);
        chk_reg("mid_rst_info", INFO, 32'h0);
        chk_vec("mid_rst_vec", 32'h0000_0180);
        tick();
        chk_reg("held_through_rst", STATUS, 32'h0);
        src_done = 2'b00;
        tick();

        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries, required 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
